// File: rtl/trivium_pkg.sv
// -----------------------------------------------------------------------------
// trivium_pkg
// Shared constants and types for the Trivium keystream generator.
//   KEY_W, IV_W      : key and IV widths (80 bits each)
//   STATE_W          : width of the internal state s1..s288
//   WARMUP_BITS_DEF  : default number of initialisation steps (4 x 288)
//   T*_ taps         : 1-based state indices (eSTREAM numbering)
//   state_t          : FSM encoding for trivium_stream
//   load_state()     : builds the initial state from key and IV
// State vectors are stored with s_i at bit position i-1.
// -----------------------------------------------------------------------------
package trivium_pkg;

   localparam int KEY_W           = 80;
   localparam int IV_W            = 80;
   localparam int STATE_W         = 288;
   localparam int WARMUP_BITS_DEF = 1152;

   // 0-based position of s94, where the IV starts
   localparam int IV_BASE = 93;

   // Output taps
   localparam int T1_A = 66;
   localparam int T1_B = 93;
   localparam int T2_A = 162;
   localparam int T2_B = 177;
   localparam int T3_A = 243;
   localparam int T3_B = 288;

   // Feedback taps: AND pair plus cross-register XOR
   localparam int T1_AND_A = 91;
   localparam int T1_AND_B = 92;
   localparam int T1_X     = 171;
   localparam int T2_AND_A = 175;
   localparam int T2_AND_B = 176;
   localparam int T2_X     = 264;
   localparam int T3_AND_A = 286;
   localparam int T3_AND_B = 287;
   localparam int T3_X     = 69;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WARMUP = 2'd1,
      RUN    = 2'd2
   } state_t;

   // key[79] lands in s1 and iv[79] in s94, so both words are bit-reversed
   // into the state; s286..s288 are set to one.
   function automatic logic [STATE_W-1:0] load_state(
      input logic [KEY_W-1:0] k,
      input logic [IV_W-1:0]  v
   );
      logic [STATE_W-1:0] s;
      s = '0;
      for (int j = 0; j < KEY_W; j++) s[j] = k[KEY_W-1-j];
      for (int j = 0; j < IV_W; j++)  s[IV_BASE+j] = v[IV_W-1-j];
      s[STATE_W-1 -: 3] = 3'b111;
      return s;
   endfunction

endpackage

// File: rtl/trivium_round.sv
// -----------------------------------------------------------------------------
// trivium_round
// One serial Trivium step, purely combinational.
//   s_in  [287:0] : current state (s_i at bit i-1)
//   s_out [287:0] : state after one step
//   z             : keystream bit produced by this step
// -----------------------------------------------------------------------------
module trivium_round
   import trivium_pkg::*;
(
   input  logic [STATE_W-1:0] s_in,
   output logic [STATE_W-1:0] s_out,
   output logic               z
);

   logic o1, o2, o3;
   logic t1, t2, t3;

   assign o1 = s_in[T1_A-1] ^ s_in[T1_B-1];
   assign o2 = s_in[T2_A-1] ^ s_in[T2_B-1];
   assign o3 = s_in[T3_A-1] ^ s_in[T3_B-1];
   assign z  = o1 ^ o2 ^ o3;

   assign t1 = o1 ^ (s_in[T1_AND_A-1] & s_in[T1_AND_B-1]) ^ s_in[T1_X-1];
   assign t2 = o2 ^ (s_in[T2_AND_A-1] & s_in[T2_AND_B-1]) ^ s_in[T2_X-1];
   assign t3 = o3 ^ (s_in[T3_AND_A-1] & s_in[T3_AND_B-1]) ^ s_in[T3_X-1];

   // Three shift registers: s1..s93, s94..s177, s178..s288. Each takes its
   // new head bit from the feedback of the previous register in the ring.
   assign s_out[0]       = t3;
   assign s_out[92:1]    = s_in[91:0];
   assign s_out[93]      = t1;
   assign s_out[176:94]  = s_in[175:93];
   assign s_out[177]     = t2;
   assign s_out[287:178] = s_in[286:177];

endmodule

// File: rtl/trivium_stream.sv
// -----------------------------------------------------------------------------
// trivium_stream
// Trivium keystream generator producing W bits per accepted word with a
// valid/ready output handshake.
//   clk, rst        : clock, synchronous active-high reset
//   load            : one-cycle request to start a new key/IV (beats handshake)
//   key, iv [79:0]  : key (key[79] -> s1), IV (iv[79] -> s94)
//   busy            : load / warm-up in progress
//   ks_valid        : ks_data holds a valid word
//   ks_ready        : consumer accepts the word
//   ks_data [W-1:0] : keystream word, bit 0 earliest
// Optional build macro TRIVIUM_STREAM_XOR_EN adds input pt_data[W-1:0] and
// drives ks_data = pt_data ^ keystream (in-block encryption).
// -----------------------------------------------------------------------------
module trivium_stream
   import trivium_pkg::*;
#(
   parameter int W           = 1,
   parameter int WARMUP_BITS = WARMUP_BITS_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [KEY_W-1:0] key,
   input  logic [IV_W-1:0]  iv,
   output logic             busy,
   output logic             ks_valid,
   input  logic             ks_ready,
`ifdef TRIVIUM_STREAM_XOR_EN
   input  logic [W-1:0]     pt_data,
`endif
   output logic [W-1:0]     ks_data
);

   localparam int WARMUP_CLKS = WARMUP_BITS / W;
   localparam int CNT_W       = $clog2(WARMUP_CLKS) + 1;

   state_t             st;
   logic [STATE_W-1:0] s;
   logic [STATE_W-1:0] s_adv;
   logic [CNT_W-1:0]   cnt;
   logic [W-1:0]       z;

   // W rounds chained combinationally: s_adv is the state W steps ahead and
   // z[i] is the keystream bit of step i, which is also what RUN presents.
   for (genvar g = 0; g < W; g++) begin : g_step
      logic [STATE_W-1:0] s_in;
      logic [STATE_W-1:0] s_out;
      if (g == 0) begin : g_first
         assign s_in = s;
      end else begin : g_next
         assign s_in = g_step[g-1].s_out;
      end
      trivium_round u_round (
         .s_in  (s_in),
         .s_out (s_out),
         .z     (z[g])
      );
   end
   assign s_adv = g_step[W-1].s_out;

`ifdef TRIVIUM_STREAM_XOR_EN
   assign ks_data = pt_data ^ z;
`else
   assign ks_data = z;
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register sees the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the 288-bit state is reset too; an all-zero state yields
         // z = 0, which keeps ks_data at 0 after reset.
         st       <= IDLE;
         s        <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
         ks_valid <= 1'b0;
      end else if (load) begin
         // A word handshaken in this same cycle is simply dropped.
         st       <= WARMUP;
         s        <= load_state(key, iv);
         cnt      <= '0;
         busy     <= 1'b1;
         ks_valid <= 1'b0;
      end else begin
         case (st)
            WARMUP: begin
               s   <= s_adv;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(WARMUP_CLKS - 1)) begin
                  st       <= RUN;
                  busy     <= 1'b0;
                  ks_valid <= 1'b1;
               end
            end
            RUN: begin
               if (ks_valid && ks_ready) s <= s_adv;
            end
            default: begin
               st       <= IDLE;
               busy     <= 1'b0;
               ks_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trivium_stream.sv
// -----------------------------------------------------------------------------
// tb_trivium_stream
// Self-checking bench for trivium_stream. Two instances share clk/rst/key/iv:
// dut1 (W=1) and dut8 (W=8). Expected keystream comes from a serial
// bit-array model of the cipher written directly from the s1..s288 numbering.
// -----------------------------------------------------------------------------
module tb_trivium_stream;

   localparam int REF_N = 1024;
   localparam logic [79:0] KEY_A = 80'h9719CFC92A9FF688F9AA;
   localparam logic [79:0] IV_A  = 80'hECBB76B09AFF71D0D151;
   localparam logic [79:0] KEY_B = 80'h0123456789ABCDEF0123;
   localparam logic [79:0] IV_B  = 80'h00000000000000000000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [79:0] key = '0;
   logic [79:0] iv  = '0;

   logic        ld1 = 1'b0, rdy1 = 1'b1, busy1, v1;
   logic [0:0]  d1;
   logic        ld8 = 1'b0, rdy8 = 1'b1, busy8, v8;
   logic [7:0]  d8;
`ifdef TRIVIUM_STREAM_XOR_EN
   logic [0:0]  pt1 = '0;
   logic [7:0]  pt8 = '0;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int pos8        = 0;

   bit ref_bits [0:REF_N-1];

   always #5 clk = ~clk;

   trivium_stream #(.W(1)) dut1 (
      .clk      (clk),
      .rst      (rst),
      .load     (ld1),
      .key      (key),
      .iv       (iv),
      .busy     (busy1),
      .ks_valid (v1),
      .ks_ready (rdy1),
`ifdef TRIVIUM_STREAM_XOR_EN
      .pt_data  (pt1),
`endif
      .ks_data  (d1)
   );

   trivium_stream #(.W(8)) dut8 (
      .clk      (clk),
      .rst      (rst),
      .load     (ld8),
      .key      (key),
      .iv       (iv),
      .busy     (busy8),
      .ks_valid (v8),
      .ks_ready (rdy8),
`ifdef TRIVIUM_STREAM_XOR_EN
      .pt_data  (pt8),
`endif
      .ks_data  (d8)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Serial reference: 1152 discarded steps, then REF_N keystream bits.
   task automatic build_ref(input logic [79:0] k, input logic [79:0] v);
      bit m [1:288];
      bit t1, t2, t3;
      for (int i = 1; i <= 288; i++) m[i] = 1'b0;
      for (int i = 1; i <= 80; i++) m[i] = k[80-i];
      for (int i = 1; i <= 80; i++) m[93+i] = v[80-i];
      m[286] = 1'b1; m[287] = 1'b1; m[288] = 1'b1;
      for (int n = 0; n < 1152 + REF_N; n++) begin
         t1 = m[66] ^ m[93];
         t2 = m[162] ^ m[177];
         t3 = m[243] ^ m[288];
         if (n >= 1152) ref_bits[n-1152] = t1 ^ t2 ^ t3;
         t1 = t1 ^ (m[91] & m[92]) ^ m[171];
         t2 = t2 ^ (m[175] & m[176]) ^ m[264];
         t3 = t3 ^ (m[286] & m[287]) ^ m[69];
         for (int i = 288; i >= 2; i--) m[i] = m[i-1];
         m[1]   = t3;
         m[94]  = t1;
         m[178] = t2;
      end
   endtask

   function automatic logic [7:0] ref_byte(input int idx);
      logic [7:0] r;
      for (int b = 0; b < 8; b++) r[b] = ref_bits[8*idx+b];
      return r;
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      tick; tick;
      vectors += 6;
      if (busy1 !== 1'b0) begin miscompares++; $display("FAIL reset_busy1 got %b exp 0", busy1); end
      if (v1 !== 1'b0)    begin miscompares++; $display("FAIL reset_valid1 got %b exp 0", v1); end
      if (d1 !== 1'b0)    begin miscompares++; $display("FAIL reset_data1 got %b exp 0", d1); end
      if (busy8 !== 1'b0) begin miscompares++; $display("FAIL reset_busy8 got %b exp 0", busy8); end
      if (v8 !== 1'b0)    begin miscompares++; $display("FAIL reset_valid8 got %b exp 0", v8); end
      if (d8 !== 8'h00)   begin miscompares++; $display("FAIL reset_data8 got %h exp 00", d8); end
      rst = 1'b0;
      tick;
   endtask

   task automatic test_w1_stream;
      int cnt;
      key = KEY_A; iv = IV_A;
      rdy1 = 1'b1;
      ld1 = 1'b1; tick; ld1 = 1'b0;
      cnt = 0;
      while (busy1 === 1'b1 && cnt < 2000) begin tick; cnt++; end
      vectors += 2;
      if (cnt != 1152) begin miscompares++; $display("FAIL w1_busy_clocks got %0d exp 1152", cnt); end
      if (v1 !== 1'b1) begin miscompares++; $display("FAIL w1_valid got %b exp 1", v1); end
      for (int i = 0; i < 512; i++) begin
         vectors++;
         if (d1 !== ref_bits[i]) begin
            miscompares++;
            $display("FAIL w1_bit[%0d] got %b exp %b", i, d1, ref_bits[i]);
         end
         tick;
      end
   endtask

   task automatic test_w8_stream;
      int cnt;
      rdy8 = 1'b1;
      ld8 = 1'b1; tick; ld8 = 1'b0;
      cnt = 0;
      while (busy8 === 1'b1 && cnt < 400) begin tick; cnt++; end
      vectors += 2;
      if (cnt != 144)  begin miscompares++; $display("FAIL w8_busy_clocks got %0d exp 144", cnt); end
      if (v8 !== 1'b1) begin miscompares++; $display("FAIL w8_valid got %b exp 1", v8); end
      for (int i = 0; i < 64; i++) begin
         vectors++;
         if (d8 !== ref_byte(i)) begin
            miscompares++;
            $display("FAIL w8_byte[%0d] got %h exp %h", i, d8, ref_byte(i));
         end
         tick;
      end
      pos8 = 64;
   endtask

   task automatic test_stall;
      rdy8 = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick;
         vectors++;
         if (d8 !== ref_byte(pos8)) begin
            miscompares++;
            $display("FAIL stall_hold[%0d] got %h exp %h", c, d8, ref_byte(pos8));
         end
      end
      rdy8 = 1'b1;
      for (int i = 0; i < 16; i++) begin
         vectors++;
         if (d8 !== ref_byte(pos8)) begin
            miscompares++;
            $display("FAIL stall_resume[%0d] got %h exp %h", pos8, d8, ref_byte(pos8));
         end
         tick;
         pos8++;
      end
   endtask

`ifdef TRIVIUM_STREAM_XOR_EN
   task automatic test_xor;
      rdy8 = 1'b0;
      pt8 = 8'h00; #1;
      vectors++;
      if (d8 !== ref_byte(pos8)) begin
         miscompares++; $display("FAIL xor_zero got %h exp %h", d8, ref_byte(pos8));
      end
      pt8 = 8'hFF; #1;
      vectors++;
      if (d8 !== ~ref_byte(pos8)) begin
         miscompares++; $display("FAIL xor_ones got %h exp %h", d8, ~ref_byte(pos8));
      end
      pt8 = 8'h00;
      rdy8 = 1'b1;
      tick;
      pos8++;
   endtask
`endif

   task automatic test_load_in_run;
      int cnt;
      rdy8 = 1'b1;
      ld8 = 1'b1; tick; ld8 = 1'b0;
      vectors += 2;
      if (busy8 !== 1'b1) begin miscompares++; $display("FAIL reload_busy got %b exp 1", busy8); end
      if (v8 !== 1'b0)    begin miscompares++; $display("FAIL reload_valid got %b exp 0", v8); end
      cnt = 0;
      while (busy8 === 1'b1 && cnt < 400) begin tick; cnt++; end
      vectors++;
      if (cnt != 144) begin miscompares++; $display("FAIL reload_busy_clocks got %0d exp 144", cnt); end
      for (int i = 0; i < 16; i++) begin
         vectors++;
         if (d8 !== ref_byte(i)) begin
            miscompares++;
            $display("FAIL reload_byte[%0d] got %h exp %h", i, d8, ref_byte(i));
         end
         tick;
      end
   endtask

   task automatic test_rst_in_warmup;
      int cnt;
      rdy1 = 1'b1;
      ld1 = 1'b1; tick; ld1 = 1'b0;
      for (int c = 1; c < 500; c++) tick;
      vectors++;
      if (busy1 !== 1'b1) begin miscompares++; $display("FAIL abort_pre_busy got %b exp 1", busy1); end
      // rst and load together: reset must win
      rst = 1'b1; ld1 = 1'b1; tick; rst = 1'b0; ld1 = 1'b0;
      vectors += 3;
      if (busy1 !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b exp 0", busy1); end
      if (v1 !== 1'b0)    begin miscompares++; $display("FAIL abort_valid got %b exp 0", v1); end
      if (d1 !== 1'b0)    begin miscompares++; $display("FAIL abort_data got %b exp 0", d1); end
      tick;
      vectors++;
      if (busy1 !== 1'b0) begin miscompares++; $display("FAIL abort_idle_busy got %b exp 0", busy1); end
      // Fresh load with a second key/IV pattern
      key = KEY_B; iv = IV_B;
      build_ref(KEY_B, IV_B);
      ld1 = 1'b1; tick; ld1 = 1'b0;
      cnt = 0;
      while (busy1 === 1'b1 && cnt < 2000) begin tick; cnt++; end
      vectors += 2;
      if (cnt != 1152) begin miscompares++; $display("FAIL abort_rewarm_clocks got %0d exp 1152", cnt); end
      if (v1 !== 1'b1) begin miscompares++; $display("FAIL abort_rewarm_valid got %b exp 1", v1); end
      for (int i = 0; i < 64; i++) begin
         vectors++;
         if (d1 !== ref_bits[i]) begin
            miscompares++;
            $display("FAIL keyb_bit[%0d] got %b exp %b", i, d1, ref_bits[i]);
         end
         tick;
      end
   endtask

   initial begin
      build_ref(KEY_A, IV_A);
      test_reset;
      test_w1_stream;
      test_w8_stream;
      test_stall;
`ifdef TRIVIUM_STREAM_XOR_EN
      test_xor;
`endif
      test_load_in_run;
      test_rst_in_warmup;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/trivium_stream.md
TRIVIUM_STREAM -- requirements
Module: trivium_stream

Interface
REQ-001 SHALL have parameter W, default 1, meaning keystream bits produced per accepted word; legal values 1, 2, 4, 8, 16, 32, 64.
REQ-002 SHALL have parameter WARMUP_BITS, default 1152, meaning the number of initialisation clocks in bits; it SHALL be a multiple of W.
REQ-003 SHALL have port clk, input, 1, meaning the single clock.
REQ-004 SHALL have port rst, input, 1, meaning synchronous, active-high reset.
REQ-005 SHALL have port load, input, 1, meaning a single-cycle request to start a new key/IV.
REQ-006 SHALL have port key, input, 80, meaning the key; key[79] maps to state bit s1.
REQ-007 SHALL have port iv, input, 80, meaning the IV; iv[79] maps to state bit s94.
REQ-008 SHALL have port busy, output, 1, meaning a load or warm-up is in progress.
REQ-009 SHALL have port ks_valid, output, 1, meaning ks_data holds a valid word.
REQ-010 SHALL have port ks_ready, input, 1, meaning the consumer accepts the word.
REQ-011 SHALL have port ks_data, output, W, meaning the keystream word; ks_data[0] is the earliest bit.

Function
REQ-012 SHALL use a 288-bit state s1..s288 (eSTREAM numbering) with FSM states IDLE, WARMUP and RUN.
REQ-013 SHALL, on load=1 in any state, register the state as s1..s80=key, s81..s93=0, s94..s173=iv, s174..s177=0, s178..s285=0, s286..s288=1, and then enter WARMUP.
REQ-014 SHALL apply one Trivium step per bit: t1=s66^s93, t2=s162^s177, t3=s243^s288, z=t1^t2^t3.
REQ-015 SHALL, within the same step, update t1^=s91&s92^s171, t2^=s175&s176^s264, t3^=s286&s287^s69.
REQ-016 SHALL, within the same step, shift in t3 at s1, t1 at s94 and t2 at s178.
REQ-017 SHALL apply W unrolled steps per advancing clock, so that one advance equals W serial steps.
REQ-018 SHALL, in WARMUP, advance every clock for WARMUP_BITS/W clocks, counted by a counter of width clog2(WARMUP_BITS/W)+1 that is cleared on load, and then enter RUN.
REQ-019 SHALL hold busy=1 throughout WARMUP and ks_valid=0 in IDLE and WARMUP.
REQ-020 SHALL, in RUN, hold ks_valid=1 and drive ks_data combinationally from the current state (the z of the next W steps), with zero added latency.
REQ-021 SHALL advance the state in RUN only when ks_valid and ks_ready are both 1; while ks_ready=0, ks_data SHALL remain stable.
REQ-022 SHALL give load priority over a simultaneous handshake: the word presented in that cycle counts as accepted by the consumer but is discarded, and the next cycle is WARMUP.
REQ-023 SHALL make the first RUN word after warm-up equal keystream bits 0..W-1.
REQ-024 SHALL produce a serial concatenation of accepted words that is identical for every W, given the same key and IV.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, force state IDLE, busy=0, ks_valid=0, counter=0 and s all-zero; ks_data is then 0.
REQ-026 SHALL give rst priority over load, and SHALL let rst abort WARMUP or RUN with no partial output.

Configuration
REQ-027 SHALL, when TRIVIUM_STREAM_XOR_EN is defined, add input pt_data[W-1:0] and drive ks_data=pt_data^z, giving in-block encryption with the same handshake.
REQ-028 SHALL, when TRIVIUM_STREAM_XOR_EN is undefined, omit pt_data and drive ks_data=z.

Structure
REQ-029 SHALL place in package trivium_pkg: the KEY_W=80 and IV_W=80 constants, the tap index constants, the FSM state typedef, and the default WARMUP_BITS.
REQ-030 SHALL implement one serial step (state in, state out, z out) in sub-module trivium_round, instantiated W times in a chain.

Verification
REQ-031 SHALL verify: W=1, key=80'h9719CFC92A9FF688F9AA, iv=80'hECBB76B09AFF71D0D151, load pulse -> busy=1 for exactly 1152 clocks, then ks_valid=1, and the first 512 bits match the golden C model.
REQ-032 SHALL verify: W=8 with the same key/IV -> busy for 144 clocks, and 64 accepted bytes equal the W=1 stream packed LSB-first.
REQ-033 SHALL verify: W=8, ks_ready held 0 for 20 clocks mid-RUN -> ks_data constant throughout, and the stream after release has no gap and no duplicate.
REQ-034 SHALL verify: load asserted in RUN together with a handshake -> that word is dropped, busy=1 on the next clock, and the stream restarts at bit 0 after warm-up.
REQ-035 SHALL verify: rst asserted at warm-up clock 500 -> next clock IDLE, busy=0, ks_valid=0; a following load warms up for the full 1152/W clocks.
REQ-036 SHALL verify: with TRIVIUM_STREAM_XOR_EN, pt_data=0 -> keystream; pt_data=8'hFF -> bitwise complement of the keystream.
